// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I/RV64I control unit:
// major-opcode encodings, access-size codes taken from func3[1:0],
// and the control FSM state encoding.
package ctrl_pkg;

    // Major opcodes the control unit knows how to sequence.
    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] S_TYPE = 7'b0100011;

    // Access size taken from func3[1:0]. LBU/LHU/LWU carry func3[2]=1
    // and reuse the same size code.
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } ctrl_state_e;

endpackage

// File: rtl/store_strobe_gen.sv
// Byte write strobes and alignment check for one data access.
// Ports: func3/ofs/is_store in; strobes (stores only, zero for loads) out;
//        misaligned out only when MISALIGN_TRAP_EN is defined.
// Purely combinational; shifted strobes are truncated to STRB_W bits.
module store_strobe_gen
    import ctrl_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int STRB_W = XLEN / 8,
    localparam int OFS_W  = $clog2(XLEN / 8)
) (
    input  logic [2:0]        func3,
    input  logic [OFS_W-1:0]  ofs,
    input  logic              is_store,
`ifdef MISALIGN_TRAP_EN
    output logic              misaligned,
`endif
    output logic [STRB_W-1:0] strobes
);

    localparam logic [STRB_W-1:0] BYTE_MASK = STRB_W'(1);
    localparam logic [STRB_W-1:0] HALF_MASK = STRB_W'(2'b11);
    localparam logic [STRB_W-1:0] WORD_MASK = STRB_W'(4'hF);

    logic [1:0]        size;
    logic              size_ok;
    logic [STRB_W-1:0] shifted;

    assign size    = func3[1:0];
    // Stores with func3[2] set have no defined width: they complete
    // without writing. Loads with func3[2] set are the unsigned variants.
    assign size_ok = !(is_store && func3[2]);

    always_comb begin
        shifted = '0;
        if (size_ok) begin
            case (size)
                SZ_BYTE:  shifted = BYTE_MASK << ofs;
                SZ_HALF:  shifted = HALF_MASK << ofs;
                SZ_WORD:  shifted = WORD_MASK << ofs;
                SZ_DWORD: if (XLEN == 64) shifted = '1;
                default:  shifted = '0;
            endcase
        end
    end

    assign strobes = is_store ? shifted : '0;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        if (size_ok) begin
            case (size)
                SZ_HALF:  misaligned = ofs[0];
                SZ_WORD:  misaligned = (ofs[1:0] != 2'b00);
                SZ_DWORD: misaligned = (XLEN == 64) && (ofs != '0);
                default:  misaligned = 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with a
// ready-based unified memory handshake and byte-strobe generation.
// Ports: clk/rst; opcode/func3/addr_ofs/mem_ready in; fetch_req,
//        instr_load, mem_req, store_enable, mem_write_enable, reg_write,
//        pc_write, illegal_instr, misaligned out.
// Optional MISALIGN_TRAP_EN: misaligned accesses divert to TRAP instead
// of reaching memory; otherwise misaligned is tied 0.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter  int XLEN   = 32,
    localparam int STRB_W = XLEN / 8,
    localparam int OFS_W  = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic [OFS_W-1:0]  addr_ofs,
    input  logic              mem_ready,
    output logic              fetch_req,
    output logic              instr_load,
    output logic              mem_req,
    output logic              store_enable,
    output logic [STRB_W-1:0] mem_write_enable,
    output logic              reg_write,
    output logic              pc_write,
    output logic              illegal_instr,
    output logic              misaligned
);

    ctrl_state_e       state_q, state_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [2:0]        func3_q, func3_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d;

    logic              is_alu, is_mem, is_store;
    logic [OFS_W-1:0]  gen_ofs;
    logic [STRB_W-1:0] strb_w;
    logic              mis_w;

    assign is_alu   = (opcode_q == R_TYPE) || (opcode_q == I_TYPE);
    assign is_store = (opcode_q == S_TYPE);
    assign is_mem   = (opcode_q == LOAD) || is_store;

    // The live offset is only needed for the EXECUTE branch decision; in
    // MEM the generator sees latched fields only, so the strobes stay
    // stable for the whole access regardless of addr_ofs.
    assign gen_ofs = (state_q == ST_EXECUTE) ? addr_ofs : ofs_q;

    store_strobe_gen #(.XLEN(XLEN)) u_strb (
        .func3      (func3_q),
        .ofs        (gen_ofs),
        .is_store   (is_store),
`ifdef MISALIGN_TRAP_EN
        .misaligned (mis_w),
`endif
        .strobes    (strb_w)
    );

`ifndef MISALIGN_TRAP_EN
    assign mis_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            opcode_q <= '0;
            func3_q  <= '0;
            ofs_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            func3_q  <= func3_d;
            ofs_q    <= ofs_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        opcode_d         = opcode_q;
        func3_d          = func3_q;
        ofs_d            = ofs_q;
        fetch_req        = 1'b0;
        instr_load       = 1'b0;
        mem_req          = 1'b0;
        store_enable     = 1'b0;
        mem_write_enable = '0;
        reg_write        = 1'b0;
        pc_write         = 1'b0;
        illegal_instr    = 1'b0;
        misaligned       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                fetch_req  = 1'b1;
                instr_load = mem_ready;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                opcode_d = opcode;
                func3_d  = func3;
                state_d  = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                ofs_d = addr_ofs;
                if (is_alu) begin
                    state_d = ST_WRITEBACK;
                end else if (is_mem) begin
                    state_d = mis_w ? ST_TRAP : ST_MEM;
                end else begin
                    illegal_instr = 1'b1;
                    pc_write      = 1'b1;
                    state_d       = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req          = 1'b1;
                store_enable     = is_store;
                mem_write_enable = strb_w;
                if (mem_ready) begin
                    pc_write = is_store;
                    state_d  = is_store ? ST_FETCH : ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = ST_FETCH;
            end
`ifdef MISALIGN_TRAP_EN
            ST_TRAP: begin
                misaligned = 1'b1;
                state_d    = ST_FETCH;
            end
`endif
            default: state_d = ST_FETCH;
        endcase

        // Outputs are silent for the whole reset cycle, including a reset
        // landing mid-access, so no strobe or write escapes.
        if (rst) begin
            fetch_req        = 1'b0;
            instr_load       = 1'b0;
            mem_req          = 1'b0;
            store_enable     = 1'b0;
            mem_write_enable = '0;
            reg_write        = 1'b0;
            pc_write         = 1'b0;
            illegal_instr    = 1'b0;
            misaligned       = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit at XLEN=32 and XLEN=64.
// Both instances run the same instruction stream in lockstep; each record
// selects which instance's outputs are compared.
module tb_multicycle_control_unit;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_ILL, K_TRAP} kind_e;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] ofs;
        int         fw;     // FETCH cycles before mem_ready
        int         mw;     // MEM cycles before mem_ready
        kind_e      kind;
        logic [7:0] strb;   // expected strobes during MEM
        logic       x64;    // compare the XLEN=64 instance
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [1:0] addr_ofs;
    logic [2:0] addr_ofs64;
    logic       mem_ready;

    logic       fetch_req, instr_load, mem_req, store_enable, reg_write, pc_write, illegal_instr, misaligned;
    logic [3:0] mwe;
    logic       fetch_req64, instr_load64, mem_req64, store_enable64, reg_write64, pc_write64, illegal_instr64, misaligned64;
    logic [7:0] mwe64;

    int n_cmp = 0;
    int n_err = 0;
    rec_t tbl[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .addr_ofs(addr_ofs),
        .mem_ready(mem_ready), .fetch_req(fetch_req), .instr_load(instr_load),
        .mem_req(mem_req), .store_enable(store_enable), .mem_write_enable(mwe),
        .reg_write(reg_write), .pc_write(pc_write), .illegal_instr(illegal_instr),
        .misaligned(misaligned)
    );

    multicycle_control_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .addr_ofs(addr_ofs64),
        .mem_ready(mem_ready), .fetch_req(fetch_req64), .instr_load(instr_load64),
        .mem_req(mem_req64), .store_enable(store_enable64), .mem_write_enable(mwe64),
        .reg_write(reg_write64), .pc_write(pc_write64), .illegal_instr(illegal_instr64),
        .misaligned(misaligned64)
    );

    function automatic rec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] ofs,
                                input int fw, input int mw, input kind_e kind,
                                input logic [7:0] strb, input logic x64);
        rec_t r;
        r.op = op; r.f3 = f3; r.ofs = ofs; r.fw = fw; r.mw = mw;
        r.kind = kind; r.strb = strb; r.x64 = x64;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Control bits: {fetch_req, instr_load, mem_req, store_enable,
    //                reg_write, pc_write, illegal_instr, misaligned}
    task automatic chk(input string name, input logic [7:0] exp_ctrl,
                       input logic [7:0] exp_strb, input logic x64);
        logic [7:0] ctrl;
        logic [7:0] strb;
        #1;
        if (x64) begin
            ctrl = {fetch_req64, instr_load64, mem_req64, store_enable64,
                    reg_write64, pc_write64, illegal_instr64, misaligned64};
            strb = mwe64;
        end else begin
            ctrl = {fetch_req, instr_load, mem_req, store_enable,
                    reg_write, pc_write, illegal_instr, misaligned};
            strb = {4'h0, mwe};
        end
        n_cmp++;
        if (ctrl !== exp_ctrl || strb !== exp_strb) begin
            n_err++;
            $display("FAIL %s @%0t: ctrl=%b strb=%h, expected ctrl=%b strb=%h",
                     name, $time, ctrl, strb, exp_ctrl, exp_strb);
        end
    endtask

    // Runs one instruction from FETCH back to FETCH, checking every cycle.
    // rst_at >= 0 asserts reset in that MEM cycle instead of completing.
    task automatic run(input rec_t r, input int rst_at);
        logic st;
        logic ill;
        for (int i = 0; i <= r.fw; i++) begin
            mem_ready = (i == r.fw);
            chk("fetch", {1'b1, logic'(i == r.fw), 6'b0}, 8'h00, r.x64);
            step();
        end
        // DECODE: mem_ready high here must be ignored.
        opcode = r.op; func3 = r.f3; mem_ready = 1'b1;
        chk("decode", 8'h00, 8'h00, r.x64);
        step();
        // Scramble opcode/func3 to prove they were latched in DECODE.
        opcode = 7'h00; func3 = 3'b111;
        addr_ofs = r.ofs[1:0]; addr_ofs64 = r.ofs;
        ill = (r.kind == K_ILL);
        chk("execute", {5'b0, ill, ill, 1'b0}, 8'h00, r.x64);
        step();
        addr_ofs = ~r.ofs[1:0]; addr_ofs64 = ~r.ofs;
        case (r.kind)
            K_TRAP: begin
                chk("trap", 8'b0000_0001, 8'h00, r.x64);
                step();
            end
            K_ALU: begin
                chk("wb_alu", 8'b0000_1100, 8'h00, r.x64);
                step();
            end
            K_LOAD, K_STORE: begin
                st = (r.kind == K_STORE);
                for (int i = 0; i <= r.mw; i++) begin
                    if (i == rst_at) begin
                        rst = 1'b1; mem_ready = 1'b0;
                        chk("rst_in_mem", 8'h00, 8'h00, r.x64);
                        step();
                        rst = 1'b0;
                        chk("after_rst", 8'b1000_0000, 8'h00, r.x64);
                        return;
                    end
                    mem_ready = (i == r.mw);
                    chk("mem", {2'b00, 1'b1, st, 1'b0, logic'(st && i == r.mw), 2'b00},
                        r.strb, r.x64);
                    step();
                end
                if (!st) begin
                    mem_ready = 1'b0;
                    chk("wb_load", 8'b0000_1100, 8'h00, r.x64);
                    step();
                end
            end
            default: ;
        endcase
        mem_ready = 1'b0;
        chk("back_fetch", 8'b1000_0000, 8'h00, r.x64);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // op, f3, ofs, fetch wait, mem wait, kind, strobes, x64
        tbl.push_back(mk(7'b0110011, 3'b000, 3'd0, 0, 0, K_ALU,   8'h00, 1'b0));
        tbl.push_back(mk(7'b0010011, 3'b000, 3'd0, 2, 0, K_ALU,   8'h00, 1'b0));
        tbl.push_back(mk(7'b0100011, 3'b000, 3'd2, 0, 2, K_STORE, 8'h04, 1'b0));
        tbl.push_back(mk(7'b0100011, 3'b001, 3'd2, 0, 0, K_STORE, 8'h0C, 1'b0));
        tbl.push_back(mk(7'b0100011, 3'b010, 3'd0, 1, 1, K_STORE, 8'h0F, 1'b0));
        tbl.push_back(mk(7'b0000011, 3'b010, 3'd0, 0, 1, K_LOAD,  8'h00, 1'b0));
        tbl.push_back(mk(7'b1111111, 3'b000, 3'd0, 0, 0, K_ILL,   8'h00, 1'b0));
        tbl.push_back(mk(7'b1101111, 3'b000, 3'd0, 0, 0, K_ILL,   8'h00, 1'b0));
        tbl.push_back(mk(7'b0100011, 3'b011, 3'd0, 0, 0, K_STORE, 8'h00, 1'b0));
        tbl.push_back(mk(7'b0100011, 3'b100, 3'd1, 0, 0, K_STORE, 8'h00, 1'b0));
        tbl.push_back(mk(7'b0000011, 3'b100, 3'd3, 0, 0, K_LOAD,  8'h00, 1'b0));
`ifdef MISALIGN_TRAP_EN
        tbl.push_back(mk(7'b0100011, 3'b010, 3'd1, 0, 0, K_TRAP,  8'h00, 1'b0));
        tbl.push_back(mk(7'b0100011, 3'b001, 3'd3, 0, 0, K_TRAP,  8'h00, 1'b0));
        tbl.push_back(mk(7'b0000011, 3'b001, 3'd1, 0, 0, K_TRAP,  8'h00, 1'b0));
`else
        tbl.push_back(mk(7'b0100011, 3'b010, 3'd1, 0, 0, K_STORE, 8'h0E, 1'b0));
        tbl.push_back(mk(7'b0100011, 3'b001, 3'd3, 0, 0, K_STORE, 8'h08, 1'b0));
        tbl.push_back(mk(7'b0000011, 3'b001, 3'd1, 0, 0, K_LOAD,  8'h00, 1'b0));
`endif
        // XLEN=64 instance
        tbl.push_back(mk(7'b0100011, 3'b011, 3'd0, 0, 1, K_STORE, 8'hFF, 1'b1));
        tbl.push_back(mk(7'b0100011, 3'b010, 3'd4, 0, 0, K_STORE, 8'hF0, 1'b1));
        tbl.push_back(mk(7'b0100011, 3'b001, 3'd6, 0, 0, K_STORE, 8'hC0, 1'b1));
        tbl.push_back(mk(7'b0100011, 3'b000, 3'd7, 0, 0, K_STORE, 8'h80, 1'b1));
        tbl.push_back(mk(7'b0110011, 3'b000, 3'd0, 0, 0, K_ALU,   8'h00, 1'b1));

        // Reset: all outputs low during the reset cycles, on both widths.
        rst = 1'b1; opcode = '0; func3 = '0; addr_ofs = '0; addr_ofs64 = '0; mem_ready = 1'b1;
        chk("reset32", 8'h00, 8'h00, 1'b0);
        chk("reset64", 8'h00, 8'h00, 1'b1);
        step();
        chk("reset32_b", 8'h00, 8'h00, 1'b0);
        step();
        rst = 1'b0;

        foreach (tbl[i]) run(tbl[i], -1);

        // Reset landing in the second MEM wait cycle of a slow LW.
        run(mk(7'b0000011, 3'b010, 3'd0, 0, 4, K_LOAD, 8'h00, 1'b0), 1);
        // Same for a store on the 64-bit instance; strobes must vanish too.
        run(mk(7'b0100011, 3'b011, 3'd0, 0, 4, K_STORE, 8'hFF, 1'b1), 1);
        // Normal traffic resumes after the interrupted accesses.
        run(mk(7'b0110011, 3'b000, 3'd0, 0, 0, K_ALU, 8'h00, 1'b0), -1);
        run(mk(7'b0100011, 3'b000, 3'd1, 0, 0, K_STORE, 8'h02, 1'b0), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
